// File: rtl/i2c_edid_pkg.sv
// i2c_edid_pkg: shared state encoding and DDC constants for the E-DDC EDID slave
package i2c_edid_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_SEG, ST_WORD, ST_WR_DATA, ST_RD, ST_RD_ACK, ST_ACK, ST_IGNORE
  } state_e;
  localparam logic [6:0] DDC_DEV_ADDR = 7'h50;
  localparam logic [6:0] DDC_SEG_ADDR = 7'h30;
  localparam logic [7:0] OOR_FILL = 8'hFF;
endpackage

// File: rtl/i2c_pin_filter.sv
// i2c_pin_filter: 2-flop synchroniser plus FILTER_LEN-sample glitch filter for SCL/SDA,
// both lines share one pipeline so their delays match; emits edge and START/STOP events
module i2c_pin_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);
  logic [1:0] s1_q, s2_q, f_q, p_q;
  logic [2:0] cnt_q [2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q  <= '1;
      s2_q  <= '1;
      f_q   <= '1;
      p_q   <= '1;
      cnt_q <= '{default: '0};
    end else begin
      s1_q <= {sda_i, scl_i};
      s2_q <= s1_q;
      p_q  <= f_q;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= (s2_q[i] == f_q[i] || cnt_q[i] == 3'(FILTER_LEN - 1)) ? 3'd0 : cnt_q[i] + 3'd1;
        if (s2_q[i] != f_q[i] && cnt_q[i] == 3'(FILTER_LEN - 1)) f_q[i] <= s2_q[i];
      end
    end
  assign scl_f     = f_q[0];
  assign sda_f     = f_q[1];
  assign scl_rise  = f_q[0] & ~p_q[0];
  assign scl_fall  = ~f_q[0] & p_q[0];
  assign start_det = f_q[0] & p_q[0] & ~f_q[1] & p_q[1];
  assign stop_det  = f_q[0] & p_q[0] & f_q[1] & ~p_q[1];
endmodule

// File: rtl/i2c_edid_ddc_slave.sv
// i2c_edid_ddc_slave: E-DDC slave serving multi-segment EDID from an external synchronous memory
// over the DDC I2C bus, with segment pointer, glitch filtering and optional write support
module i2c_edid_ddc_slave
  import i2c_edid_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DDC_DEV_ADDR,
  parameter logic [6:0] SEG_ADDR    = DDC_SEG_ADDR,
  parameter int         SEG_W       = 1,
  parameter int         FILTER_LEN  = 4,
  parameter int         ALLOW_WRITE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [SEG_W+7:0] mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic [7:0]       mem_wdata,
  output logic             mem_we,
  output logic             busy,
  output logic             rd_done
);
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
  state_e state_q, state_d, nxt_q, nxt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, off_q, off_d, wdata_q, wdata_d, rd_byte;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic oor_q, oor_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d, we_q, we_d, rx_bit;
  i2c_pin_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
    .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det)
  );
  assign rx_bit  = sda_f & scl_f;
  assign rd_byte = oor_q ? OOR_FILL : mem_rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      nxt_q   <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      seg_q   <= '0;
      oor_q   <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      seg_q   <= seg_d;
      oor_q   <= oor_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
    end
  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    off_d   = we_q ? off_q + 8'd1 : off_q;
    wdata_d = wdata_q;
    seg_d   = seg_q;
    oor_d   = oor_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      seg_d   = '0;
      oor_d   = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_SEG, ST_WORD, ST_WR_DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            sh_d  = {sh_q[6:0], rx_bit};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d = ST_ACK;
            oe_d    = 1'b1;
            cnt_d   = '0;
            case (state_q)
              ST_ADDR:
                if (sh_q[7:1] == DEV_ADDR) begin
                  busy_d = 1'b1;
                  nxt_d  = sh_q[0] ? ST_RD : ST_WORD;
                end else if (sh_q[7:1] == SEG_ADDR && !sh_q[0]) nxt_d = ST_SEG;
                else begin
                  state_d = ST_IGNORE;
                  oe_d    = 1'b0;
                end
              ST_SEG: begin
                seg_d = sh_q[SEG_W-1:0];
                oor_d = |(sh_q >> SEG_W);
                nxt_d = ST_IGNORE;
              end
              ST_WORD: begin
                off_d = sh_q;
                nxt_d = ST_WR_DATA;
              end
              default:
                if (ALLOW_WRITE != 0) begin
                  we_d    = 1'b1;
                  wdata_d = sh_q;
                  nxt_d   = ST_WR_DATA;
                end else begin
                  state_d = ST_IGNORE;
                  oe_d    = 1'b0;
                end
            endcase
          end
        end
        ST_ACK:
          if (scl_fall) begin
            state_d = nxt_q;
            cnt_d   = '0;
            oe_d    = (nxt_q == ST_RD) ? ~rd_byte[7] : 1'b0;
            sh_d    = (nxt_q == ST_RD) ? rd_byte : sh_q;
          end
        ST_RD:
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          else if (scl_fall && cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            off_d   = off_q + 8'd1;
            state_d = ST_RD_ACK;
            cnt_d   = '0;
          end else if (scl_fall && cnt_q != 4'd0) begin
            sh_d = {sh_q[6:0], 1'b0};
            oe_d = ~sh_q[6];
          end
        ST_RD_ACK:
          // cnt_q=1 marks a master ACK; the next byte starts on the following SCL fall
          if (scl_rise) begin
            if (rx_bit) begin
              done_d  = 1'b1;
              state_d = ST_IGNORE;
            end else cnt_d = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = ST_RD;
            cnt_d   = '0;
            sh_d    = rd_byte;
            oe_d    = ~rd_byte[7];
          end
        default: ;
      endcase
    end
  end
  assign sda_oe    = oe_q & ~rst;
  assign mem_addr  = {seg_q, off_q};
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign busy      = busy_q;
  assign rd_done   = done_q;
endmodule

// File: tb/tb_i2c_edid_ddc_slave.sv
// tb_i2c_edid_ddc_slave: bit-banged DDC master driving a read-only and a writable slave instance
module tb_i2c_edid_ddc_slave;
  localparam int Q = 10;
  typedef struct {
    logic       do_seg;
    logic [7:0] seg;
    logic [7:0] off;
    logic [8:0] exp_addr;
    logic [7:0] exp_data;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1, sel = 1'b0;
  logic scl0, scl1, sda_bus, oe0, oe1, we0, we1, busy0, busy1, done0, done1;
  logic [8:0] addr0, addr1, we1_addr;
  logic [7:0] rd0, rd1, wd0, wd1, we1_data;
  logic [7:0] mem1 [512];
  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, we0_cnt = 0, we1_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  assign scl0 = sel ? 1'b1 : m_scl;
  assign scl1 = sel ? m_scl : 1'b1;
  assign sda_bus = m_sda & ~oe0 & ~oe1;
  always #5 clk = ~clk;
  i2c_edid_ddc_slave #(.ALLOW_WRITE(0)) dut0 (
    .clk(clk), .rst(rst), .scl_i(scl0), .sda_i(sda_bus), .sda_oe(oe0), .mem_addr(addr0),
    .mem_rdata(rd0), .mem_wdata(wd0), .mem_we(we0), .busy(busy0), .rd_done(done0)
  );
  i2c_edid_ddc_slave #(.ALLOW_WRITE(1)) dut1 (
    .clk(clk), .rst(rst), .scl_i(scl1), .sda_i(sda_bus), .sda_oe(oe1), .mem_addr(addr1),
    .mem_rdata(rd1), .mem_wdata(wd1), .mem_we(we1), .busy(busy1), .rd_done(done1)
  );
  function automatic logic [7:0] f(input logic [8:0] a);
    return a[7:0] ^ (a[8] ? 8'hC3 : 8'h3C);
  endfunction
  always @(posedge clk) begin
    rd0 <= f(addr0);
    rd1 <= mem1[addr1];
    if (we1) begin
      mem1[addr1] <= wd1;
      we1_cnt <= we1_cnt + 1;
      we1_addr <= addr1;
      we1_data <= wd1;
    end
    if (done0) done_cnt <= done_cnt + 1;
    if (we0) we0_cnt <= we0_cnt + 1;
    if (oe0) oe_cnt <= oe_cnt + 1;
    if (busy0) busy_cnt <= busy_cnt + 1;
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; w(Q); m_scl = 1'b1; w(Q); m_sda = 1'b0; w(Q); m_scl = 1'b0; w(Q);
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; w(Q); m_scl = 1'b1; w(Q); m_sda = 1'b1; w(Q);
  endtask
  task automatic i2c_bit(input logic b, input logic glitch, output logic r);
    m_sda = b; w(Q); m_scl = 1'b1;
    if (glitch) begin w(3); m_scl = 1'b0; w(2); m_scl = 1'b1; w(Q - 5); end else w(Q);
    r = sda_bus; w(Q); m_scl = 1'b0;
    if (glitch) begin w(3); m_scl = 1'b1; w(2); m_scl = 1'b0; w(Q - 5); end else w(Q);
  endtask
  task automatic wr_byte(input logic [7:0] b, input logic [7:0] gmask, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], gmask[i], r);
    i2c_bit(1'b1, 1'b0, ack);
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] d, output logic [8:0] a);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 1'b0, r);
      d[i] = r;
      if (i == 7) a = sel ? addr1 : addr0;
    end
    i2c_bit(nack, 1'b0, r);
  endtask
  task automatic xfer(input logic do_seg, input logic [7:0] seg, input logic [7:0] off,
                      output logic nak, output logic [7:0] d, output logic [8:0] ad);
    logic a;
    nak = 1'b0;
    if (do_seg) begin
      i2c_start; wr_byte(8'h60, 8'h00, a); nak |= a; wr_byte(seg, 8'h00, a); nak |= a;
    end
    i2c_start; wr_byte(8'hA0, 8'h00, a); nak |= a; wr_byte(off, 8'h00, a); nak |= a;
    i2c_start; wr_byte(8'hA1, 8'h00, a); nak |= a;
    rd_byte(1'b1, d, ad);
    i2c_stop; w(20);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic a, nak;
    logic [7:0] d;
    logic [8:0] ad;
    int s_done, s_we0, s_we1, s_oe, s_busy;
    vec_t vt[5];
    vt[0] = '{1'b0, 8'h00, 8'h10, 9'h010, 8'h2C};
    vt[1] = '{1'b1, 8'h01, 8'h20, 9'h120, 8'hE3};
    vt[2] = '{1'b0, 8'h00, 8'h20, 9'h020, 8'h1C};
    vt[3] = '{1'b1, 8'h03, 8'h05, 9'h105, 8'hFF};
    vt[4] = '{1'b0, 8'h00, 8'hFF, 9'h0FF, 8'hC3};
    for (int i = 0; i < 512; i++) mem1[i] = f(9'(i));
    w(5);
    chk("reset sda_oe", oe0, 0);
    chk("reset mem_addr", addr0, 0);
    chk("reset mem_we", we0, 0);
    chk("reset busy", busy0, 0);
    chk("reset rd_done", done0, 0);
    rst = 1'b0; w(10);
    s_done = done_cnt;
    i2c_start; wr_byte(8'hA0, 8'h00, a); chk("seq read addr ack", a, 0);
    chk("busy after addr", busy0, 1);
    wr_byte(8'h00, 8'h00, a); chk("seq read offset ack", a, 0);
    i2c_start; wr_byte(8'hA1, 8'h00, a); chk("seq read addr_r ack", a, 0);
    for (int i = 0; i < 4; i++) begin
      rd_byte(i == 3, d, ad);
      chk("seq read data", d, f(9'(i)));
      chk("seq read addr", ad, i);
    end
    chk("busy before stop", busy0, 1);
    i2c_stop; w(20);
    chk("busy after stop", busy0, 0);
    chk("rd_done pulses", done_cnt - s_done, 1);
    i2c_start; wr_byte(8'h60, 8'h00, a); chk("seg addr ack", a, 0);
    wr_byte(8'h01, 8'h00, a); chk("seg value ack", a, 0);
    i2c_start; wr_byte(8'hA0, 8'h00, a); wr_byte(8'h80, 8'h00, a); chk("seg offset ack", a, 0);
    i2c_start; wr_byte(8'hA1, 8'h00, a); chk("seg read addr ack", a, 0);
    rd_byte(1'b0, d, ad); chk("seg rd0 addr", ad, 9'h180); chk("seg rd0 data", d, f(9'h180));
    rd_byte(1'b1, d, ad); chk("seg rd1 addr", ad, 9'h181); chk("seg rd1 data", d, f(9'h181));
    i2c_stop; w(20);
    xfer(1'b0, 8'h00, 8'h00, nak, d, ad);
    chk("seg cleared addr", ad, 9'h000); chk("seg cleared data", d, 8'h3C);
    i2c_start; wr_byte(8'hA0, 8'h00, a); wr_byte(8'hFE, 8'h00, a);
    i2c_start; wr_byte(8'hA1, 8'h00, a);
    for (int i = 0; i < 3; i++) begin
      rd_byte(i == 2, d, ad);
      chk("wrap addr", ad, (9'h0FE + 9'(i)) & 9'h0FF);
      chk("wrap data", d, f((9'h0FE + 9'(i)) & 9'h0FF));
    end
    i2c_stop; w(20);
    s_oe = oe_cnt; s_busy = busy_cnt;
    i2c_start; wr_byte(8'hA4, 8'h00, a); chk("foreign addr nack", a, 1);
    wr_byte(8'h00, 8'h00, a); chk("foreign data nack", a, 1);
    i2c_stop; w(20);
    chk("foreign sda_oe cycles", oe_cnt - s_oe, 0);
    chk("foreign busy cycles", busy_cnt - s_busy, 0);
    s_we0 = we0_cnt;
    i2c_start; wr_byte(8'hA0, 8'h00, a); chk("ro write addr ack", a, 0);
    wr_byte(8'h10, 8'h00, a); chk("ro write offset ack", a, 0);
    wr_byte(8'h55, 8'h00, a); chk("ro write data nack", a, 1);
    i2c_stop; w(20);
    chk("ro mem_we count", we0_cnt - s_we0, 0);
    sel = 1'b1; w(20);
    s_we1 = we1_cnt;
    i2c_start; wr_byte(8'hA0, 8'h00, a); chk("rw write addr ack", a, 0);
    wr_byte(8'h10, 8'h00, a); chk("rw write offset ack", a, 0);
    wr_byte(8'h55, 8'h00, a); chk("rw write data ack", a, 0);
    i2c_stop; w(20);
    chk("rw mem_we count", we1_cnt - s_we1, 1);
    chk("rw mem_we addr", we1_addr, 9'h010);
    chk("rw mem_we data", we1_data, 8'h55);
    sel = 1'b0; w(20);
    for (int i = 0; i < 5; i++) begin
      xfer(vt[i].do_seg, vt[i].seg, vt[i].off, nak, d, ad);
      chk("vec acks", nak, 0);
      chk("vec addr", ad, vt[i].exp_addr);
      chk("vec data", d, vt[i].exp_data);
    end
    i2c_start; wr_byte(8'hA0, 8'b0010_0100, a); chk("glitch addr ack", a, 0);
    wr_byte(8'h00, 8'b1000_0001, a); chk("glitch offset ack", a, 0);
    i2c_start; wr_byte(8'hA1, 8'h00, a); chk("glitch read addr ack", a, 0);
    chk("read bit driven", oe0, 1);
    m_sda = 1'b1; w(Q); m_scl = 1'b1; w(3);
    rst = 1'b1; #1;
    chk("async reset sda_oe", oe0, 0);
    chk("async reset busy", busy0, 0);
    m_scl = 1'b1; m_sda = 1'b1; w(5);
    chk("reset mem_addr mid-read", addr0, 0);
    rst = 1'b0; w(20);
    xfer(1'b0, 8'h00, 8'h05, nak, d, ad);
    chk("post reset acks", nak, 0);
    chk("post reset addr", ad, 9'h005);
    chk("post reset data", d, 8'h39);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_edid_ddc_slave.md
Name: i2c_edid_ddc_slave

Overview:
Parametrised E-DDC slave serving EDID data to an HDMI/DVI source over the DDC I2C bus. It supersedes the single-block EDID responder and adds:
- configurable device and segment addresses;
- multi-segment EDID (E-DDC segment pointer at 0x30);
- glitch filtering;
- an optional writable mode.
It sits in hdmi_in beside the TMDS receiver and reads an external synchronous EDID memory through a simple read/write port.

Parameters:
DEV_ADDR, 7'h50, 7-bit EDID device address
SEG_ADDR, 7'h30, 7-bit E-DDC segment pointer address
SEG_W, 1, segment pointer width; memory holds 2**SEG_W segments of 256 bytes
FILTER_LEN, 4, consecutive equal samples required to accept a new SCL/SDA level (2..8)
ALLOW_WRITE, 0, 1 = accept master writes into memory; 0 = NACK write data bytes

Ports:
clk  in  1  system clock; must be at least 20x the SCL bit rate
rst  in  1  asynchronous active-high reset
scl_i  in  1  DDC SCL from pad (asynchronous)
sda_i  in  1  DDC SDA from pad (asynchronous)
sda_oe  out  1  1 = pull SDA low (open-drain); pad drives 'z' otherwise
mem_addr  out  SEG_W+8  {segment, offset} memory address
mem_rdata  in  8  memory read data, valid one clk after mem_addr changes
mem_wdata  out  8  write data
mem_we  out  1  one-clk write strobe
busy  out  1  high from an addressed START until STOP
rd_done  out  1  one-clk pulse when the master NACKs a read byte (EDID read finished)

Behaviour:
- Reset values: sda_oe=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, rd_done=0, segment=0, offset=0, state=IDLE.
- Input conditioning:
  - scl_i and sda_i pass through a 2-flop synchroniser, then a FILTER_LEN-sample filter.
  - Filtered edge/START/STOP events lag the pins by 2+FILTER_LEN clk.
- Bus events:
  - START (repeated or not) = filtered SDA falls while SCL is high. From any state: reload the bit counter, release SDA, go to ADDR.
  - STOP = SDA rises while SCL is high. From any state: release SDA, go to IDLE, clear busy, reset segment to 0.
- Bit timing:
  - Sample SDA on the filtered SCL rising edge.
  - Change sda_oe only on the filtered SCL falling edge, so the filter delay provides hold time.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - addr==DEV_ADDR → ACK, busy=1, then RD if R/W=1, else WORD.
    - addr==SEG_ADDR with W → ACK, SEG.
    - SEG_ADDR with R, or any other address → IGNORE; sda_oe stays 0.
  - SEG: shift 8 bits, ACK, latch the low SEG_W bits into segment, go to IGNORE_ACKED (wait for repeated START).
  - WORD: shift 8 bits, ACK, load offset; then WR_DATA.
  - WR_DATA:
    - ALLOW_WRITE=1: shift 8 bits, ACK, pulse mem_we with mem_addr={segment,offset}, then offset+1.
    - ALLOW_WRITE=0: NACK and go to IGNORE.
  - RD: present mem_addr={segment,offset}. After one clk, load the shift register from mem_rdata (or 8'hFF if segment ≥ 2**SEG_W). Drive the bits MSB first, then offset+1.
  - RD_ACK: release SDA and sample the master ACK.
    - ACK=0 → RD with prefetch of the next byte.
    - ACK=1 → pulse rd_done, go to IGNORE.
  - IGNORE: release SDA, wait for START/STOP.
- ACK timing: SDA is held low from the SCL falling edge after bit 8 until the next SCL falling edge.
- Offset wrap: 8'hFF+1 → 8'h00; the segment is unchanged.
- Segment retention: the segment survives a repeated START but is cleared by STOP.
- Simultaneous events: START/STOP take priority over any in-progress SCL edge in the same clk.
- Async reset mid-transfer releases SDA immediately (combinational path from rst to sda_oe low).

Decomposition:
- Package i2c_edid_pkg holds:
  - the state encoding;
  - DDC address constants (7'h50, 7'h30);
  - the 8'hFF out-of-range fill value.
- One sub-module, i2c_pin_filter: synchroniser plus FILTER_LEN filter, with outputs scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det. It is instantiated once for both lines so their delays match.

Test Plan:
- Reset, then START, 0xA0, offset 0x00, repeated START, 0xA1, read 4 bytes with ACK,ACK,ACK,NACK, then STOP → ACK bits low; data = mem[0..3]; exactly one rd_done pulse; busy falls at STOP.
- Write 0x60 with segment 0x01, repeated START, 0xA0, offset 0x80, repeated START, 0xA1, read 2 bytes → mem_addr 0x180 and 0x181 are read; after STOP, a fresh read at offset 0 returns segment 0.
- Read starting at offset 0xFE, 3 bytes → mem_addr sequence 0x0FE, 0x0FF, 0x000 (wrap, segment kept).
- Address 0xA4 (not DEV_ADDR) → sda_oe stays 0 for the whole transaction; busy stays 0.
- ALLOW_WRITE=0: write 0xA0, 0x10, 0x55 → offset byte ACKed, data byte NACKed, mem_we never asserted. ALLOW_WRITE=1: same sequence → one mem_we at 0x010 with data 0x55, then ACK.
- Glitch test: SCL pulses shorter than FILTER_LEN clk are inserted mid-byte, then rst is asserted during a read bit → no extra bit is counted; sda_oe goes to 0 asynchronously and state returns to IDLE.
